mext_mul_unit: RTL and testbench
================================

MEXT_MUL_UNIT -- requirements
Module: mext_mul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EX-stage M-extension multiply request; held until resp_valid.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- rs1, rs2  in  WIDTH each  source operands.
- flush  in  1  kill the in-flight request.
- stall  out  1  pipeline hold.
- resp_valid  out  1  one-cycle result strobe.
- rd_data  out  WIDTH  result.
- mul_start  out  1  start to the unsigned array multiplier.
- mul_a, mul_b  out  WIDTH each  unsigned magnitudes to the multiplier.
- mul_product  in  2*WIDTH  multiplier result.
- mul_done  in  1  one-cycle multiplier completion strobe.

Function
REQ-003 SHALL treat req_valid with funct3[2]=1 as out of scope: not accepted, stall low, no response.
REQ-004 SHALL derive signedness as follows: rs1 signed for MUL, MULH and MULHSU; rs2 signed for MUL and MULH only.
REQ-005 SHALL set each operand's neg flag to MSB AND signed; mul_x = neg ? two's-complement negation : operand, so 0x80000000 becomes 0x80000000 unsigned.
REQ-006 SHALL compute the 2*WIDTH corrected result as (negA XOR negB) ? -mul_product : mul_product; negation of zero SHALL yield zero.
REQ-007 SHALL drive rd_data with the corrected result: bits [WIDTH-1:0] for MUL, bits [2*WIDTH-1:WIDTH] otherwise.
REQ-008 SHALL implement a state machine with states IDLE, ISSUE, WAIT, RESP and DRAIN.
REQ-009 IDLE: on a valid request without flush, SHALL capture operands and op; a cache hit goes to RESP, otherwise to ISSUE.
REQ-010 ISSUE: SHALL assert mul_start for exactly one cycle, then go to WAIT.
REQ-011 WAIT: SHALL wait unbounded for mul_done; on mul_done, SHALL register the corrected result, update the cache and go to RESP.
REQ-012 RESP: resp_valid = 1 AND NOT flush, for one cycle; rd_data is registered; SHALL then return to IDLE.
REQ-013 Miss latency: request first sampled in IDLE at cycle 0, resp_valid at cycle 4 with a 2-cycle multiplier. Hit latency: resp_valid at cycle 1, mul_start never asserted.
REQ-014 Cache: a single entry of {valid, rs1, rs2, signA, signB, 2*WIDTH corrected result}.
REQ-015 Cache hit rule: MULH*/MULHU hit requires equal operands and equal signedness; MUL hits on equal operands regardless of signedness.
REQ-016 stall = req_valid AND NOT resp_valid AND NOT funct3[2], combinational.
REQ-017 flush in IDLE SHALL have no effect, and a request in the same cycle SHALL not be accepted.
REQ-018 flush in RESP SHALL suppress resp_valid.
REQ-019 flush in ISSUE or WAIT without mul_done SHALL go to DRAIN; DRAIN waits for mul_done then goes to IDLE without a cache update and without resp_valid.
REQ-020 flush coincident with mul_done in WAIT SHALL go to IDLE with no cache update.
REQ-021 While in DRAIN, SHALL hold stall for any new request.

Reset
REQ-022 On rst, SHALL enter IDLE.
REQ-023 On rst, SHALL set to zero: mul_start, resp_valid, rd_data, mul_a, mul_b, cache valid and all captured registers.
REQ-024 rst mid-operation SHALL abort with no response; the multiplier shares rst, so DRAIN is not required after reset.

Structure
REQ-025 A shared package SHALL hold the mul_op_t funct3 enum (MUL, MULH, MULHSU, MULHU) and the state enum.
REQ-026 SHALL instantiate no sub-module; the multiplier SHALL be instantiated beside this block at EX-stage level.
REQ-027 The sign-correction and selection logic SHALL be one combinational function in the package.

Verification
REQ-028 MUL rs1=7, rs2=0xFFFFFFFD -> resp_valid at cycle 4, rd_data=0xFFFFFFEB.
REQ-029 rs1=rs2=0x80000000 -> MULH 0x40000000, MULHU 0x40000000, MULHSU 0xC0000000.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; then MUL with same operands -> hit, resp_valid at cycle 1, rd_data=0x00000001, no mul_start.
REQ-031 MULHSU rs1=0xFFFFFFFF, rs2=0 -> rd_data=0x00000000.
REQ-032 MUL 3x5 with flush at cycle 2 -> no resp_valid; DRAIN until mul_done; the next 3x5 misses (mul_start asserted) and returns 0x0000000F.
REQ-033 rst asserted in WAIT -> next cycle all outputs 0 and IDLE; a repeat request misses.

Source files
------------

// File: rtl/mext_mul_unit_pkg.sv
`default_nettype none
// ============================================================================
// mext_mul_unit_pkg : shared op/state types and product fix-up function
// Rev 1.0
// ============================================================================
package mext_mul_unit_pkg;

    // Widest operand the fix-up function supports; narrower units zero-pad.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011
    } mul_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } mul_state_t;

    typedef struct packed {
        logic [2*MAX_WIDTH-1:0] full;
        logic [MAX_WIDTH-1:0]   rd;
    } mul_fix_t;

    // Restores the sign of an unsigned magnitude product, then picks the
    // low half for MUL or the high half (at bit 'width') for the MULH family.
    function automatic mul_fix_t mul_fixup(
        input logic [2*MAX_WIDTH-1:0] product,
        input logic                   flip,
        input mul_op_t                op,
        input int unsigned            width
    );
        mul_fix_t res;
        res.full = flip ? -product : product;
        res.rd   = (op == OP_MUL) ? MAX_WIDTH'(res.full)
                                  : MAX_WIDTH'(res.full >> width);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mext_mul_unit.sv
`default_nettype none
// ============================================================================
// mext_mul_unit : RV M-extension multiply sequencer with a one-entry result cache
// Rev 1.0
// ============================================================================
module mext_mul_unit
    import mext_mul_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [2:0]         funct3,
    input  logic [WIDTH-1:0]   rs1,
    input  logic [WIDTH-1:0]   rs2,
    input  logic               flush,
    output logic               stall,
    output logic               resp_valid,
    output logic [WIDTH-1:0]   rd_data,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_done
);

    mul_state_t             state;
    mul_state_t             state_next;
    mul_op_t                req_op;
    mul_op_t                op_q;

    logic [WIDTH-1:0]       rs1_q;
    logic [WIDTH-1:0]       rs2_q;
    logic                   sign_a_q;
    logic                   sign_b_q;
    logic                   flip_q;

    logic                   cache_valid;
    logic [WIDTH-1:0]       cache_rs1;
    logic [WIDTH-1:0]       cache_rs2;
    logic                   cache_sign_a;
    logic                   cache_sign_b;
    logic [2*WIDTH-1:0]     cache_result;

    logic                   sign_a;
    logic                   sign_b;
    logic                   neg_a;
    logic                   neg_b;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic                   cache_hit;
    logic                   capture;
    logic                   load_hit;
    logic                   load_miss;

    logic [2*MAX_WIDTH-1:0] hit_product;
    logic [2*MAX_WIDTH-1:0] miss_product;
    mul_fix_t               fix_hit;
    mul_fix_t               fix_miss;
    logic                   unused_fix_bits;

    assign req_op = mul_op_t'(funct3);
    assign sign_a = (req_op != OP_MULHU);
    assign sign_b = (req_op == OP_MUL) || (req_op == OP_MULH);
    assign neg_a  = rs1[WIDTH-1] & sign_a;
    assign neg_b  = rs2[WIDTH-1] & sign_b;
    assign mag_a  = neg_a ? -rs1 : rs1;
    assign mag_b  = neg_b ? -rs2 : rs2;

    // Low half of a product is signedness-independent, so MUL ignores it.
    assign cache_hit = cache_valid && (rs1 == cache_rs1) && (rs2 == cache_rs2) &&
                       ((req_op == OP_MUL) ||
                        ((sign_a == cache_sign_a) && (sign_b == cache_sign_b)));

    // Cached results are already sign-corrected, so no flip on a hit.
    assign hit_product  = (2*MAX_WIDTH)'(cache_result);
    assign miss_product = (2*MAX_WIDTH)'(mul_product);
    assign fix_hit      = mul_fixup(hit_product, 1'b0, req_op, WIDTH);
    assign fix_miss     = mul_fixup(miss_product, flip_q, op_q, WIDTH);
    assign unused_fix_bits = ^{fix_hit, fix_miss};

    assign stall = req_valid & ~resp_valid & ~funct3[2];

    always_comb begin
        state_next = state;
        resp_valid = 1'b0;
        capture    = 1'b0;
        load_hit   = 1'b0;
        load_miss  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && !flush && !funct3[2]) begin
                    capture = 1'b1;
                    if (cache_hit) begin
                        load_hit   = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    if (flush) begin
                        state_next = ST_IDLE;
                    end else begin
                        load_miss  = 1'b1;
                        state_next = ST_RESP;
                    end
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_RESP: begin
                resp_valid = ~flush;
                state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                // The multiplier cannot be cancelled; swallow its result.
                if (mul_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            rd_data      <= '0;
            op_q         <= OP_MUL;
            rs1_q        <= '0;
            rs2_q        <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            flip_q       <= 1'b0;
            cache_valid  <= 1'b0;
            cache_rs1    <= '0;
            cache_rs2    <= '0;
            cache_sign_a <= 1'b0;
            cache_sign_b <= 1'b0;
            cache_result <= '0;
        end else begin
            state     <= state_next;
            mul_start <= (state_next == ST_ISSUE);
            if (capture) begin
                op_q     <= req_op;
                rs1_q    <= rs1;
                rs2_q    <= rs2;
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                flip_q   <= neg_a ^ neg_b;
                mul_a    <= mag_a;
                mul_b    <= mag_b;
            end
            if (load_hit) begin
                rd_data <= fix_hit.rd[WIDTH-1:0];
            end
            if (load_miss) begin
                rd_data      <= fix_miss.rd[WIDTH-1:0];
                cache_valid  <= 1'b1;
                cache_rs1    <= rs1_q;
                cache_rs2    <= rs2_q;
                cache_sign_a <= sign_a_q;
                cache_sign_b <= sign_b_q;
                cache_result <= fix_miss.full[2*WIDTH-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mext_mul_unit.sv
`default_nettype none
// ============================================================================
// tb_mext_mul_unit : scoreboard bench with behavioural multiply and cache model
// Rev 1.0
// ============================================================================
module tb_mext_mul_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rd_data;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_product;
    logic        mul_done;

    mext_mul_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .stall      (stall),
        .resp_valid (resp_valid),
        .rd_data    (rd_data),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_product(mul_product),
        .mul_done   (mul_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nstarts = 0;
    int mul_lat = 2;
    logic [31:0] exp_ma = '0;
    logic [31:0] exp_mb = '0;

    typedef struct {
        logic [31:0] rd;
        int          lat;
        int          t0;
        bit          chk_lat;
    } exp_t;
    exp_t sb[$];

    // Reference cache contents
    bit          c_valid = 0;
    logic [31:0] c_a = '0;
    logic [31:0] c_b = '0;
    bit          c_sa = 0;
    bit          c_sb = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural unsigned multiplier with programmable latency
    int          mcnt = 0;
    logic [63:0] mprod = '0;
    always @(posedge clk) begin
        if (rst) begin
            mcnt  <= 0;
            mprod <= '0;
        end else if (mul_start) begin
            mcnt  <= mul_lat;
            mprod <= 64'(mul_a) * 64'(mul_b);
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mul_done    = (mcnt == 1);
    assign mul_product = mprod;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_sa(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
    endfunction

    function automatic bit is_sb(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1);
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [65:0]  x;
        logic signed [65:0]  y;
        logic signed [131:0] p;
        x = is_sa(f) ? $signed({{34{a[31]}}, a}) : $signed({34'd0, a});
        y = is_sb(f) ? $signed({{34{b[31]}}, b}) : $signed({34'd0, b});
        p = x * y;
        return (f == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] magnitude(input bit signed_op, input logic [31:0] v);
        longint s;
        s = signed_op ? longint'($signed(v)) : longint'(v);
        if (s < 0) s = -s;
        return s[31:0];
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && mul_start) begin
                nstarts++;
                chk("mul_a", 64'(mul_a), 64'(exp_ma));
                chk("mul_b", 64'(mul_b), 64'(exp_mb));
            end
            if (!rst && resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp_valid", 64'(resp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(e.rd));
                    if (e.chk_lat) chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                end
            end
        end
    end

    // Issue one request; flush_off >= 0 pulses flush that many cycles after acceptance.
    task automatic do_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_off, input bit chk_lat);
        bit   hit;
        bit   sa;
        bit   sbf;
        bit   got;
        int   st0;
        exp_t e;
        sa  = is_sa(f);
        sbf = is_sb(f);
        hit = c_valid && (c_a == a) && (c_b == b) &&
              ((f == 3'd0) || ((c_sa == sa) && (c_sb == sbf)));
        exp_ma  = magnitude(sa, a);
        exp_mb  = magnitude(sbf, b);
        mul_lat = lat;
        st0     = nstarts;
        if (flush_off < 0) begin
            e.rd      = ref_result(f, a, b);
            e.lat     = hit ? 1 : lat + 2;
            e.t0      = cyc;
            e.chk_lat = chk_lat;
            sb.push_back(e);
        end
        req_valid = 1'b1;
        funct3    = f;
        rs1       = a;
        rs2       = b;
        got       = 0;
        for (int k = 0; k < 80; k++) begin
            flush = (k == flush_off);
            @(negedge clk);
            if (k == 0) chk("stall_held", 64'(stall), 64'd1);
            if (flush_off < 0 && resp_valid) begin
                chk("stall_released", 64'(stall), 64'd0);
                got = 1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            if (k == flush_off) begin
                got = 1;
                break;
            end
        end
        flush     = 1'b0;
        req_valid = 1'b0;
        if (!got) chk("resp_timeout", 64'd0, 64'd1);
        chk("mul_starts", 64'(nstarts - st0), hit ? 64'd0 : 64'd1);
        if (!hit && (flush_off < 0 || flush_off >= lat + 2)) begin
            c_valid = 1;
            c_a     = a;
            c_b     = b;
            c_sa    = sa;
            c_sb    = sbf;
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          st0;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;

        do_req(3'd0, 32'd7, 32'hFFFF_FFFD, 2, -1, 1);
        do_req(3'd1, 32'h8000_0000, 32'h8000_0000, 2, -1, 1);
        do_req(3'd3, 32'h8000_0000, 32'h8000_0000, 2, -1, 1);
        do_req(3'd2, 32'h8000_0000, 32'h8000_0000, 2, -1, 1);
        do_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, -1, 1);
        do_req(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, -1, 1);
        do_req(3'd2, 32'hFFFF_FFFF, 32'h0, 2, -1, 1);

        // Flush while waiting, then a held request behind the drain
        do_req(3'd0, 32'd3, 32'd5, 2, 2, 1);
        do_req(3'd0, 32'd3, 32'd5, 2, -1, 0);
        // Flush coincident with mul_done, then repeat must miss
        do_req(3'd0, 32'd11, 32'd13, 2, 3, 1);
        do_req(3'd0, 32'd11, 32'd13, 2, -1, 1);
        // Flush on a hit response, then MULH hits the same entry
        do_req(3'd0, 32'd11, 32'd13, 2, 1, 1);
        do_req(3'd1, 32'd11, 32'd13, 2, -1, 1);
        // Flush in ISSUE
        do_req(3'd3, 32'd17, 32'd19, 3, 1, 1);
        do_req(3'd3, 32'd17, 32'd19, 3, -1, 0);
        // Flush in RESP of a miss still fills the cache
        do_req(3'd2, 32'hFFFF_FFE9, 32'd29, 2, 4, 1);
        do_req(3'd2, 32'hFFFF_FFE9, 32'd29, 2, -1, 1);

        // funct3[2] set: ignored
        st0       = nstarts;
        req_valid = 1'b1;
        funct3    = 3'b110;
        rs1       = $urandom;
        rs2       = $urandom;
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_of_scope", 64'(stall), 64'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        funct3    = 3'b000;
        chk("starts_out_of_scope", 64'(nstarts - st0), 64'd0);

        // Reset while waiting on the multiplier
        exp_ma    = 32'd9;
        exp_mb    = 32'd9;
        mul_lat   = 2;
        req_valid = 1'b1;
        funct3    = 3'b000;
        rs1       = 32'd9;
        rs2       = 32'd9;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_mul_start", 64'(mul_start), 64'd0);
        chk("midrst_rd_data", 64'(rd_data), 64'd0);
        chk("midrst_mul_a", 64'(mul_a), 64'd0);
        chk("midrst_mul_b", 64'(mul_b), 64'd0);
        c_valid = 0;
        @(posedge clk);
        #1;
        do_req(3'd0, 32'd9, 32'd9, 2, -1, 1);

        // Randomized traffic with frequent operand reuse to exercise the cache
        a = pick_val();
        b = pick_val();
        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) begin
                a = pick_val();
                b = pick_val();
            end
            do_req(f, a, b, $urandom_range(1, 4), -1, 1);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
